// File: rtl/pingpong_ram_scheduler_if.sv
// Producer (valid/ready) and consumer (request/valid) handshake bundle for the ping-pong scheduler.
// master = sample generator / drawer side, slave = scheduler side.
interface pingpong_ram_scheduler_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_req;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_req,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_req,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pingpong_ram_scheduler.sv
// Ping-pong controller for two line RAMs: producer fills the write bank while the consumer
// drains the other; banks swap only when the write bank is full and the read bank is empty.
module pingpong_ram_scheduler #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  pingpong_ram_scheduler_if.slave bus,
  output logic              ram1_write_en,
  output logic [ADDR_W-1:0] ram1_write_address,
  output logic [DATA_W-1:0] ram1_write_data,
  output logic              ram2_write_en,
  output logic [ADDR_W-1:0] ram2_write_address,
  output logic [DATA_W-1:0] ram2_write_data,
  output logic              ram1_read_en,
  output logic [ADDR_W-1:0] ram1_read_address,
  input  logic [DATA_W-1:0] ram1_read_data,
  output logic              ram2_read_en,
  output logic [ADDR_W-1:0] ram2_read_address,
  input  logic [DATA_W-1:0] ram2_read_data,
  output logic              wbank,
  output logic              swap_pulse,
  output logic              underrun
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic              wbank_q, wbank_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic              wr_full_q, wr_full_d;
  logic              rd_avail_q, rd_avail_d;
  logic              rd_bank_q, rd_bank_d;
  logic              out_valid_q, out_valid_d;
  logic              swap_pulse_q, swap_pulse_d;
  logic              underrun_q, underrun_d;

  logic in_ready_c;
  logic wr_acc;
  logic rd_iss;
  logic swap_cond;

  assign in_ready_c = !wr_full_q && !reset;
  assign wr_acc     = bus.in_valid && in_ready_c;
  assign rd_iss     = bus.out_req && rd_avail_q && !reset;
  // Both flags are registered, so the swap cycle itself blocks writes and reads.
  assign swap_cond  = wr_full_q && !rd_avail_q;

  assign ram1_write_en      = wr_acc && !wbank_q;
  assign ram2_write_en      = wr_acc && wbank_q;
  assign ram1_write_address = wptr_q;
  assign ram2_write_address = wptr_q;
  assign ram1_write_data    = bus.in_data;
  assign ram2_write_data    = bus.in_data;

  assign ram1_read_en       = rd_iss && wbank_q;
  assign ram2_read_en       = rd_iss && !wbank_q;
  assign ram1_read_address  = rptr_q;
  assign ram2_read_address  = rptr_q;

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  // Return data follows the bank latched at issue, so a swap right after the last read is harmless.
  assign bus.out_data  = out_valid_q ? (rd_bank_q ? ram2_read_data : ram1_read_data) : '0;

  assign wbank      = wbank_q;
  assign swap_pulse = swap_pulse_q;
  assign underrun   = underrun_q;

  always_comb begin
    wbank_d      = wbank_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    wr_full_d    = wr_full_q;
    rd_avail_d   = rd_avail_q;
    rd_bank_d    = rd_iss ? !wbank_q : rd_bank_q;
    out_valid_d  = rd_iss;
    swap_pulse_d = swap_cond;
    underrun_d   = bus.out_req && !rd_avail_q;

    if (swap_cond) begin
      wbank_d    = !wbank_q;
      wptr_d     = '0;
      rptr_d     = '0;
      wr_full_d  = 1'b0;
      rd_avail_d = 1'b1;
    end else begin
      if (wr_acc) begin
        if (wptr_q == LAST) wr_full_d = 1'b1;
        else                wptr_d    = wptr_q + 1'b1;
      end
      if (rd_iss) begin
        if (rptr_q == LAST) rd_avail_d = 1'b0;
        else                rptr_d     = rptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbank_q      <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      wr_full_q    <= 1'b0;
      rd_avail_q   <= 1'b0;
      rd_bank_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      swap_pulse_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      wbank_q      <= wbank_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      wr_full_q    <= wr_full_d;
      rd_avail_q   <= rd_avail_d;
      rd_bank_q    <= rd_bank_d;
      out_valid_q  <= out_valid_d;
      swap_pulse_q <= swap_pulse_d;
      underrun_q   <= underrun_d;
    end
  end

endmodule

// File: tb/tb_pingpong_ram_scheduler.sv
// Bench for pingpong_ram_scheduler: bank-occupancy model plus RAM models, directed scenarios
// followed by a randomized soak.
module tb_pingpong_ram_scheduler;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pingpong_ram_scheduler_if #(.DATA_W(DATA_W)) bus ();

  logic              ram1_write_en, ram2_write_en, ram1_read_en, ram2_read_en;
  logic [ADDR_W-1:0] ram1_write_address, ram2_write_address;
  logic [ADDR_W-1:0] ram1_read_address, ram2_read_address;
  logic [DATA_W-1:0] ram1_write_data, ram2_write_data;
  logic [DATA_W-1:0] ram1_read_data, ram2_read_data;
  logic              wbank, swap_pulse, underrun;

  pingpong_ram_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .ram1_write_en(ram1_write_en), .ram1_write_address(ram1_write_address),
    .ram1_write_data(ram1_write_data),
    .ram2_write_en(ram2_write_en), .ram2_write_address(ram2_write_address),
    .ram2_write_data(ram2_write_data),
    .ram1_read_en(ram1_read_en), .ram1_read_address(ram1_read_address),
    .ram1_read_data(ram1_read_data),
    .ram2_read_en(ram2_read_en), .ram2_read_address(ram2_read_address),
    .ram2_read_data(ram2_read_data),
    .wbank(wbank), .swap_pulse(swap_pulse), .underrun(underrun)
  );

  // Line RAMs driven by the DUT strobes, 1-cycle synchronous read.
  logic [DATA_W-1:0] mem1 [DEPTH];
  logic [DATA_W-1:0] mem2 [DEPTH];
  always @(posedge clk) begin
    if (ram1_write_en) mem1[ram1_write_address] <= ram1_write_data;
    if (ram2_write_en) mem2[ram2_write_address] <= ram2_write_data;
    if (ram1_read_en)  ram1_read_data <= mem1[ram1_read_address];
    if (ram2_read_en)  ram2_read_data <= mem2[ram2_read_address];
  end

  int checks = 0;
  int errors = 0;

  // Model: how many samples sit in the write bank, how many remain unread in the read bank,
  // and what each bank slot should contain.
  int        m_wbank, m_wcount, m_rem;
  bit        m_ov, m_swp, m_und;
  logic [7:0] m_od;
  logic [7:0] exp_mem [2][DEPTH];

  logic [7:0] seen_q [$];
  int pulses = 0;
  int both_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wbank = 0; m_wcount = 0; m_rem = 0;
    m_ov = 0; m_swp = 0; m_und = 0; m_od = '0;
  endtask

  // Called at posedge+1; asserts reset, checks the immediate clearing, releases after one edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_swap_pulse", swap_pulse, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_wbank", wbank, 0);
    chk("rst_enables", {ram1_write_en, ram2_write_en, ram1_read_en, ram2_read_en}, 0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // One clock: drive at posedge+1, compare at negedge, advance the model across the next edge.
  task automatic cycle(input logic iv, input logic [7:0] id, input logic oreq);
    bit acc, iss, n_ov, n_swp, n_und;
    logic [7:0] n_od;
    int ra;
    bus.in_valid = iv; bus.in_data = id; bus.out_req = oreq;
    #4;
    acc = iv && (m_wcount < DEPTH);
    iss = oreq && (m_rem > 0);
    ra  = DEPTH - m_rem;
    chk("in_ready", bus.in_ready, m_wcount < DEPTH);
    chk("wbank", wbank, m_wbank);
    chk("out_valid", bus.out_valid, m_ov);
    if (m_ov) chk("out_data", bus.out_data, m_od);
    chk("swap_pulse", swap_pulse, m_swp);
    chk("underrun", underrun, m_und);
    chk("ram1_write_en", ram1_write_en, acc && m_wbank == 0);
    chk("ram2_write_en", ram2_write_en, acc && m_wbank == 1);
    chk("ram1_read_en", ram1_read_en, iss && m_wbank == 1);
    chk("ram2_read_en", ram2_read_en, iss && m_wbank == 0);
    if (acc) begin
      chk("write_address", m_wbank ? ram2_write_address : ram1_write_address, m_wcount);
      chk("write_data", m_wbank ? ram2_write_data : ram1_write_data, id);
    end
    if (iss) chk("read_address", m_wbank ? ram2_read_address : ram1_read_address, ra);
    if (ram2_write_en && ram1_read_en) both_cnt++;
    if (swap_pulse) pulses++;
    if (bus.out_valid) seen_q.push_back(bus.out_data);

    n_ov  = iss;
    n_od  = iss ? exp_mem[1 - m_wbank][ra] : m_od;
    n_und = oreq && (m_rem == 0);
    n_swp = (m_wcount == DEPTH) && (m_rem == 0);
    @(posedge clk); #1;
    m_ov = n_ov; m_od = n_od; m_und = n_und; m_swp = n_swp;
    if (acc) begin
      exp_mem[m_wbank][m_wcount] = id;
      m_wcount++;
    end
    if (iss) m_rem--;
    if (n_swp) begin
      m_wbank  = 1 - m_wbank;
      m_wcount = 0;
      m_rem    = DEPTH;
    end
  endtask

  task automatic chk_seq(input string name, input int base);
    chk({name, "_count"}, seen_q.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < seen_q.size(); i++)
      chk(name, seen_q[i], base + i);
  endtask

  task automatic fill(input int base);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(base + i), 1'b0);
  endtask

  task automatic drain();
    seen_q.delete();
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    int p0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_req = 1'b0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Underrun straight after reset.
    cycle(1'b0, 8'h00, 1'b1);
    chk("lit_underrun", underrun, 1);
    chk("lit_underrun_ov", bus.out_valid, 0);
    cycle(1'b0, 8'h00, 1'b0);

    // Fill bank 0, then the condition cycle, then the pulse cycle.
    fill(0);
    chk("lit_full_ready", bus.in_ready, 0);
    chk("lit_no_pulse_yet", swap_pulse, 0);
    cycle(1'b0, 8'h00, 1'b0);
    chk("lit_swap_pulse", swap_pulse, 1);
    chk("lit_wbank1", wbank, 1);
    chk("lit_ready_again", bus.in_ready, 1);
    drain();
    chk_seq("lit_drain", 0);

    // Backpressure: both banks full, writes stall until bank 0 drains.
    do_reset();
    fill(0);
    cycle(1'b0, 8'h00, 1'b0);
    fill(100);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hEE, 1'b0);
    chk("lit_bp_ready", bus.in_ready, 0);
    chk("lit_bp_wbank", wbank, 1);
    drain();
    chk_seq("lit_bp_first", 0);
    chk("lit_bp_wbank0", wbank, 0);
    drain();
    chk_seq("lit_bp_second", 100);

    // Concurrent write to bank 1 and read from bank 0.
    do_reset();
    fill(0);
    cycle(1'b0, 8'h00, 1'b0);
    seen_q.delete();
    both_cnt = 0;
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(200 + i), 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    chk("lit_concurrent", both_cnt, DEPTH);
    chk_seq("lit_conc_data", 0);

    // Reset after a partial fill; the next full bank swaps exactly once.
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(i + 7), 1'b0);
    bus.in_valid = 1'b1;
    do_reset();
    p0 = pulses;
    fill(50);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0);
    chk("lit_one_swap", pulses - p0, 1);
    drain();
    chk_seq("lit_after_reset", 50);

    // Randomized soak with varying producer/consumer rates and rare resets.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      int pv, pr;
      pv = (n / 250) % 4;
      pr = (n / 400) % 3;
      if ($urandom_range(0, 799) == 0) do_reset();
      cycle($urandom_range(0, 3) < pv + 1, 8'($urandom), $urandom_range(0, 2) <= pr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pingpong_ram_scheduler.md
Name: pingpong_ram_scheduler

Overview:
- Ping-pong controller for the two 32x8 line RAMs (ram1/ram2) between the sample generator and the VGA draw path.
- Producer samples go into the write bank while the consumer drains the other bank.
- Banks swap only when the write bank is full and the read bank is fully drained, so the drawer never sees a half-written buffer.
- Replaces ad-hoc read/write sequencing with a valid/ready producer side and a request/valid consumer side.

Parameters:
ADDR_W, 5, RAM address width
DATA_W, 8, sample width
DEPTH, 32, entries per bank (must be ≤ 2^ADDR_W, ≥ 2)

Ports:
clk  in  1  single system clock, all logic rising-edge
reset  in  1  asynchronous, active-high; clears all state
in_valid  in  1  producer sample valid
in_data  in  DATA_W  producer sample
in_ready  out  1  scheduler accepts sample this cycle
out_req  in  1  consumer requests next sample
out_valid  out  1  out_data valid (1 cycle after accepted out_req)
out_data  out  DATA_W  sample read from read bank
ram1_write_en / ram2_write_en  out  1  bank write strobes
ram1_write_address / ram2_write_address  out  ADDR_W
ram1_write_data / ram2_write_data  out  DATA_W
ram1_read_en / ram2_read_en  out  1  bank read strobes
ram1_read_address / ram2_read_address  out  ADDR_W
ram1_read_data / ram2_read_data  in  DATA_W  synchronous RAM read data, 1-cycle latency
wbank  out  1  current write bank (0=ram1, 1=ram2)
swap_pulse  out  1  one-cycle pulse, the cycle after a swap edge
underrun  out  1  one-cycle pulse, out_req with nothing to read

Behaviour:
- Reset (async, active-high) values:
  - wbank=0, wptr=0, rptr=0, wr_full=0, rd_avail=0, rd_bank_q=0.
  - out_valid=0, out_data=0, swap_pulse=0, underrun=0.
  - in_ready=0 while reset is high.
  - All RAM enables 0; combinational enables gated by reset.
- Write side:
  - in_ready = !wr_full & !reset.
  - Accept when in_valid & in_ready: the write-bank write_en=1 (combinational), address=wptr, data=in_data. The other bank's write_en=0.
  - On accept, wptr increments. On accepting at wptr==DEPTH-1, wptr holds and wr_full sets.
- Read side:
  - Issue when out_req & rd_avail: read-bank (!wbank) read_en=1, address=rptr. rd_bank_q captures the bank selected.
  - Next cycle: out_valid=1 and out_data = read_data of rd_bank_q (registered).
  - rptr increments. Issuing at rptr==DEPTH-1 clears rd_avail.
  - out_req & !rd_avail -> underrun=1 and out_valid=0 next cycle; no RAM read.
- Swap:
  - Condition: registered wr_full==1 & rd_avail==0 at a rising edge.
  - At that edge: wbank toggles, wptr=0, rptr=0, wr_full=0, rd_avail=1.
  - swap_pulse=1 for the following cycle.
  - in_ready is 0 during the swap-condition cycle, and no read issues then (rd_avail=0).
- Simultaneous events:
  - Write and read in the same cycle target different banks, so no conflict.
  - The last read's data returns from rd_bank_q even when a swap edge follows immediately.
  - The earliest write to the just-drained bank is the cycle after the swap, after its last read data has been captured.
- Startup: rd_avail=0, so the first swap fires once bank 0 first fills.
- Backpressure: with wr_full=1 and rd_avail=1, in_ready stays 0 until the read bank drains. No overflow, no data loss.
- Reset mid-operation: immediately clears pointers and flags. Partial bank contents are discarded (not re-read); any in-flight out_valid is suppressed.
- Address width: pointers are ADDR_W bits and never wrap past DEPTH-1.

Test Plan:
- Fill: reset, then in_valid=1 with in_data=0..31 on consecutive cycles -> in_ready=1 for 32 accepts, ram1_write_en on addr 0..31. swap_pulse is high 2 cycles after the 32nd accept (condition cycle, swap edge, pulse cycle). wbank=1; in_ready=1 again.
- Drain: after the swap, hold out_req=1 for 32 cycles -> ram1_read_en on addr 0..31; out_valid=1 with out_data=0..31, each 1 cycle after its request; underrun stays 0.
- Underrun: out_req=1 right after reset -> underrun=1 next cycle, out_valid=0, no read_en.
- Backpressure: fill bank 0 (swap), fill bank 1 with 100..131, do not read -> in_ready=0 after 32 accepts and wbank stays 1. Issue 32 reads -> data 0..31, then swap to wbank=0 and data 100..131 become readable.
- Concurrency: stream writes and reads in the same cycles -> ram2_write_en and ram1_read_en are both high on the same cycle, and read data is unaffected.
- Reset mid-op: assert reset after 10 writes -> in_ready=0, wptr=0, outputs cleared immediately. After release, 32 new writes still trigger exactly one swap.
